tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Receives a time-multiplexed sample stream on one W-bit bus and routes each sample to one of NCH registered channel outputs. This is the inverse of the selector/mux blocks.
- A frame-sync marker on the stream identifies channel 0.
- Sits between a serial/TDM source (on-board link or test pattern generator) and per-channel consumers such as LED and 7-seg drivers.

Parameters:
- NCH, 4, number of output channels (2..16).
- W, 8, sample width in bits.
- CW, $clog2(NCH), channel counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  W  incoming TDM sample.
- din_valid  input  1  din holds a sample this cycle.
- fsync  input  1  qualified by din_valid; marks the current sample as channel 0.
- dout  output  NCH*W  channel registers; channel k at bits [k*W +: W].
- ch_stb  output  NCH  one-cycle pulse on bit k when channel k's visible value updates.
- frame_done  output  1  one-cycle pulse when the last channel (NCH-1) of a frame is accepted.
- locked  output  1  high while the state machine is in LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low at a clk edge): dout=0, ch_stb=0, frame_done=0, sync_err=0, locked=0, cnt=0, state=HUNT. Reset overrides all other inputs the same cycle. Reset mid-frame discards the partial frame; dout is cleared.
- fsync without din_valid is ignored in every state.
- State machine has two states.
- HUNT:
  - din_valid && !fsync: sample dropped, no outputs change.
  - din_valid && fsync: write ch0, cnt<=1 (or 0 if NCH==1), go LOCKED.
- LOCKED, on din_valid:
  - !fsync, cnt!=0: write ch[cnt]. If cnt==NCH-1, then cnt<=0 and frame_done pulses; else cnt<=cnt+1.
  - fsync, cnt==0: normal frame start. Write ch0, cnt<=1.
  - fsync, cnt!=0 (early sync): sync_err pulses, the partial frame is abandoned, ch0 is written with the sample, cnt<=1. Stay LOCKED; no frame_done.
  - !fsync, cnt==0 (missing sync): sync_err pulses, the sample is dropped, go HUNT, locked falls next cycle.
- LOCKED, no din_valid: hold.
- Latency:
  - dout/ch_stb/frame_done/sync_err are registered, one cycle after the accepted din_valid edge.
  - ch_stb is one-hot or zero. It coincides with the dout update.
  - frame_done coincides with ch_stb[NCH-1].
- Gaps: din_valid may be low for any number of cycles between samples. The frame position is preserved.
- Back-to-back: one sample per cycle is sustained with no bubbles.
- Unwritten channels hold their last value.

Optional Feature:
- Macro TDM_DEMUX_FRAME_LATCH_EN.
- When defined:
  - Samples are written to an internal shadow bank.
  - dout updates atomically from the shadow bank only in the cycle frame_done pulses; all ch_stb bits pulse together in that cycle.
  - Frames abandoned by early sync or missing sync never reach dout.
  - The shadow bank resets to 0.
- When undefined: per-sample update as described in Behaviour; no shadow registers are synthesized.

Test Plan (NCH=4, W=8):
- Reset, then din_valid=1 with din=0x11,0x22 and fsync=0 -> locked=0, dout=0, no ch_stb.
- fsync+0xA0, then 0xA1, 0xA2, 0xA3 back-to-back -> dout=0xA3A2A1A0 one cycle after the last sample, ch_stb 0001,0010,0100,1000, frame_done with the fourth, locked=1.
- Same frame with 3 idle cycles between each sample -> identical final dout and strobes; cnt holds across gaps.
- Frame 0xB0,0xB1 then fsync+0xC0 -> sync_err one pulse, ch0=0xC0, ch1=0xB1, next sample 0xC1 lands in ch1, no frame_done.
- Complete frame then 0xD0 without fsync -> sync_err pulse, locked=0, dout unchanged; later fsync+0xE0 relocks with ch0=0xE0.
- rst_n low after two samples of a frame -> all outputs 0 next cycle, HUNT.
- With TDM_DEMUX_FRAME_LATCH_EN: dout changes only at frame_done, ch_stb=1111.

Source files
------------

// File: rtl/tdm_demux_if.sv
// TDM stream bundle: sample/valid/frame-sync from the source, per-channel
// registers and framing status back from the demultiplexer.
interface tdm_demux_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic [W-1:0]     din;
  logic             din_valid;
  logic             fsync;
  logic [NCH*W-1:0] dout;
  logic [NCH-1:0]   ch_stb;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, fsync,
    input  dout, ch_stb, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, fsync,
    output dout, ch_stb, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes each sample of a framed stream to its channel register.
// Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames atomically via a shadow bank.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux_if.slave  bus
);
  localparam int CW = $clog2(NCH);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NCH*W-1:0] dout_q, dout_d;
  logic [NCH-1:0]   chStb_q, chStb_d;
  logic             frameDone_q, frameDone_d;
  logic             syncErr_q, syncErr_d;
  logic             wrEn;
  logic [CW-1:0]    wrIdx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wrEn        = 1'b0;
    frameDone_d = 1'b0;
    syncErr_d   = 1'b0;
    wrIdx       = bus.fsync ? '0 : cnt_q;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            wrEn    = 1'b1;
            cnt_d   = CW'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.fsync) begin
            // An early sync abandons the partial frame but keeps lock.
            wrEn      = 1'b1;
            cnt_d     = CW'(1);
            syncErr_d = (cnt_q != '0);
          end else if (cnt_q == '0) begin
            syncErr_d = 1'b1;
            state_d   = HUNT;
          end else begin
            wrEn = 1'b1;
            if (cnt_q == CW'(NCH - 1)) begin
              cnt_d       = '0;
              frameDone_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [NCH*W-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wrEn) shadow_d[int'(wrIdx)*W +: W] = bus.din;
    // The closing sample goes straight through so the frame publishes in one cycle.
    dout_d  = frameDone_d ? shadow_d : dout_q;
    chStb_d = frameDone_d ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end
`else
  always_comb begin
    dout_d = dout_q;
    if (wrEn) dout_d[int'(wrIdx)*W +: W] = bus.din;
    chStb_d = wrEn ? (NCH'(1) << wrIdx) : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      dout_q      <= '0;
      chStb_q     <= '0;
      frameDone_q <= 1'b0;
      syncErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      chStb_q     <= chStb_d;
      frameDone_q <= frameDone_d;
      syncErr_q   <= syncErr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.ch_stb     = chStb_q;
  assign bus.frame_done = frameDone_q;
  assign bus.sync_err   = syncErr_q;
  assign bus.locked     = (state_q == LOCKED);
endmodule
